// File: rtl/ucie_ig_seq.sv
`default_nettype none
// ============================================================================
// Module   : ucie_ig_seq
// Brief    : Loads a host word stream into the UCIe ingress pattern buffer,
//            programs its pointers, enables replay and waits for completion.
// Revision : 1.0 - initial release
// ============================================================================
module ucie_ig_seq #(
    parameter int DEPTH  = 32,
    parameter int DWIDTH = 32,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_loop_mode,
    input  logic [3:0]        i_num_loops,
    input  logic              i_data_valid,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_data_last,
    output logic              o_data_ready,
    output logic              o_ig_wdata_clr,
    output logic [DWIDTH-1:0] o_ig_wdata,
    output logic              o_ig_wdata_upd,
    output logic              o_ig_load_ptr,
    output logic [PW-1:0]     o_ig_start_ptr,
    output logic [PW-1:0]     o_ig_stop_ptr,
    output logic              o_ig_loop_mode,
    output logic [3:0]        o_ig_num_loops,
    output logic              o_ig_wdata_en,
    input  logic              i_ig_write_done,
    input  logic              i_ig_overflow,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [PW:0]       o_word_cnt
);

    localparam logic [PW:0] c_cnt_last = (PW+1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_UPD  = 3'd3,
        S_PTR  = 3'd4,
        S_RUN  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                last_q, last_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic [PW-1:0]       stop_q, stop_d;
    logic                loop_q, loop_d;
    logic [3:0]          num_q, num_d;
    logic                err_q, err_d;

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q <= S_IDLE;
            wdata_q <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            stop_q  <= '0;
            loop_q  <= 1'b0;
            num_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            loop_q  <= loop_d;
            num_q   <= num_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        loop_d  = loop_q;
        num_d   = num_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CLR;
                    loop_d  = i_loop_mode;
                    num_d   = i_num_loops;
                    cnt_d   = '0;
                    stop_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_CLR:  state_d = S_LOAD;
            S_LOAD: begin
                if (i_data_valid) begin
                    wdata_d = i_data;
                    last_d  = i_data_last;
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                cnt_d = cnt_q + 1'b1;
                // cnt_q is the pre-increment count, i.e. exactly the index of the word just committed
                if (last_q || (cnt_q == c_cnt_last)) begin
                    stop_d  = cnt_q[PW-1:0];
                    err_d   = err_q | ~last_q;
                    state_d = S_PTR;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_PTR:  state_d = S_RUN;
            S_RUN: begin
                if (i_ig_overflow) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (i_ig_write_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort freezes every register and only returns the FSM to IDLE
        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            wdata_d = wdata_q;
            last_d  = last_q;
            cnt_d   = cnt_q;
            stop_d  = stop_q;
            err_d   = err_q;
        end
    end

    assign o_data_ready   = (state_q == S_LOAD);
    assign o_ig_wdata_clr = (state_q == S_CLR);
    assign o_ig_wdata_upd = (state_q == S_UPD);
    assign o_ig_load_ptr  = (state_q == S_PTR);
    assign o_ig_wdata_en  = (state_q == S_RUN);
    assign o_done         = (state_q == S_DONE);
    assign o_busy         = (state_q != S_IDLE);
    assign o_ig_wdata     = wdata_q;
    assign o_ig_start_ptr = '0;
    assign o_ig_stop_ptr  = stop_q;
    assign o_ig_loop_mode = loop_q;
    assign o_ig_num_loops = num_q;
    assign o_error        = err_q;
    assign o_word_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ucie_ig_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucie_ig_seq
// Brief    : Self-checking bench for ucie_ig_seq against a sequence-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucie_ig_seq;

    localparam int DEPTH  = 32;
    localparam int DWIDTH = 32;
    localparam int PW     = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0, i_abort = 1'b0, i_loop_mode = 1'b0;
    logic [3:0]        i_num_loops = '0;
    logic              i_data_valid = 1'b0, i_data_last = 1'b0;
    logic [DWIDTH-1:0] i_data = '0;
    logic              i_ig_write_done = 1'b0, i_ig_overflow = 1'b0;
    logic              o_data_ready, o_ig_wdata_clr, o_ig_wdata_upd, o_ig_load_ptr;
    logic [DWIDTH-1:0] o_ig_wdata;
    logic [PW-1:0]     o_ig_start_ptr, o_ig_stop_ptr;
    logic              o_ig_loop_mode, o_ig_wdata_en, o_busy, o_done, o_error;
    logic [3:0]        o_ig_num_loops;
    logic [PW:0]       o_word_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned cyc = 0;

    ucie_ig_seq #(.DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
        .i_hclk(clk), .i_hreset(rst), .i_start(i_start), .i_abort(i_abort),
        .i_loop_mode(i_loop_mode), .i_num_loops(i_num_loops),
        .i_data_valid(i_data_valid), .i_data(i_data), .i_data_last(i_data_last),
        .o_data_ready(o_data_ready), .o_ig_wdata_clr(o_ig_wdata_clr),
        .o_ig_wdata(o_ig_wdata), .o_ig_wdata_upd(o_ig_wdata_upd),
        .o_ig_load_ptr(o_ig_load_ptr), .o_ig_start_ptr(o_ig_start_ptr),
        .o_ig_stop_ptr(o_ig_stop_ptr), .o_ig_loop_mode(o_ig_loop_mode),
        .o_ig_num_loops(o_ig_num_loops), .o_ig_wdata_en(o_ig_wdata_en),
        .i_ig_write_done(i_ig_write_done), .i_ig_overflow(i_ig_overflow),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_word_cnt(o_word_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return {3'd0, o_data_ready, o_ig_wdata_clr, o_ig_wdata, o_ig_wdata_upd,
                o_ig_load_ptr, o_ig_start_ptr, o_ig_stop_ptr, o_ig_loop_mode,
                o_ig_num_loops, o_ig_wdata_en, o_busy, o_done, o_error, o_word_cnt};
    endfunction

    // Accepted start; leaves the bench one cycle into CLR
    task automatic do_start(input logic lm, input logic [3:0] nl);
        i_start = 1'b1; i_loop_mode = lm; i_num_loops = nl;
        step();
        i_start = 1'b0; i_loop_mode = ~lm; i_num_loops = ~nl;
    endtask

    // Offer one word and wait for its handshake; returns in the following cycle
    task automatic feed_word(input logic [31:0] w, input logic lst, input int gap);
        int t;
        i_data_valid = 1'b0;
        repeat (gap) step();
        i_data = w; i_data_last = lst; i_data_valid = 1'b1;
        t = 0;
        while (!o_data_ready && t < 10) begin step(); t++; end
        chk("ready_seen", 64'(o_data_ready), 64'd1);
        step();
        i_data_valid = 1'b0; i_data_last = 1'b0;
    endtask

    // outcome: 0 write_done, 1 overflow, 2 both together (plus ignored starts in RUN)
    task automatic run_seq(input int n_words, input int last_idx, input int outcome, input bit no_gaps);
        logic [31:0] words[$];
        int          acc, last_upd;
        bit          trunc, exp_err;
        logic        lm;
        logic [3:0]  nl;
        trunc   = !(last_idx >= 0 && last_idx < DEPTH);
        acc     = trunc ? DEPTH : last_idx + 1;
        exp_err = trunc || (outcome != 0);
        for (int k = 0; k < n_words; k++) words.push_back($urandom);
        lm = 1'($urandom); nl = 4'($urandom);

        do_start(lm, nl);
        chk("clr_pulse", 64'(o_ig_wdata_clr), 64'd1);
        chk("clr_busy", 64'(o_busy), 64'd1);
        chk("start_err_clear", 64'(o_error), 64'd0);
        chk("start_cnt_clear", 64'(o_word_cnt), 64'd0);
        chk("loop_mode", 64'(o_ig_loop_mode), 64'(lm));
        chk("num_loops", 64'(o_ig_num_loops), 64'(nl));
        step();

        last_upd = 0;
        for (int k = 0; k < acc; k++) begin
            feed_word(words[k], 1'(k == last_idx), no_gaps ? 0 : int'($urandom_range(0, 2)));
            chk("upd_pulse", 64'(o_ig_wdata_upd), 64'd1);
            chk("upd_wdata", 64'(o_ig_wdata), 64'(words[k]));
            chk("upd_ready_low", 64'(o_data_ready), 64'd0);
            if (no_gaps && k > 0) chk("upd_spacing", 64'(cyc - 32'(last_upd)), 64'd2);
            last_upd = int'(cyc);
            step();
        end

        // PTR cycle: surplus word must not be taken; a stray overflow is ignored here
        if (n_words > acc) begin
            i_data = words[acc]; i_data_valid = 1'b1;
            chk("surplus_not_ready", 64'(o_data_ready), 64'd0);
        end
        i_ig_overflow = (outcome == 0);
        chk("load_ptr", 64'(o_ig_load_ptr), 64'd1);
        chk("stop_ptr", 64'(o_ig_stop_ptr), 64'(acc - 1));
        chk("start_ptr", 64'(o_ig_start_ptr), 64'd0);
        chk("ptr_cnt", 64'(o_word_cnt), 64'(acc));
        chk("trunc_err", 64'(o_error), 64'(trunc));
        step();
        i_ig_overflow = 1'b0; i_data_valid = 1'b0;
        chk("run_en", 64'(o_ig_wdata_en), 64'd1);
        chk("run_ready_low", 64'(o_data_ready), 64'd0);

        repeat (1 + $urandom_range(0, 2)) begin
            i_start = (outcome == 2);
            step();
            i_start = 1'b0;
            chk("run_hold", 64'({o_busy, o_ig_wdata_en, o_error}), 64'({2'b11, trunc}));
        end
        i_ig_write_done = (outcome != 1);
        i_ig_overflow   = (outcome != 0);
        step();
        i_ig_write_done = 1'b0; i_ig_overflow = 1'b0;
        chk("done_pulse", 64'(o_done), 64'd1);
        chk("done_en_low", 64'(o_ig_wdata_en), 64'd0);
        chk("done_err", 64'(o_error), 64'(exp_err));
        step();
        chk("idle_flags", 64'({o_busy, o_done}), 64'd0);
        chk("idle_cnt", 64'(o_word_cnt), 64'(acc));
        chk("idle_stop_held", 64'(o_ig_stop_ptr), 64'(acc - 1));
        chk("idle_err", 64'(o_error), 64'(exp_err));
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_outputs", all_outputs(), 64'd0);

        run_seq(4, 3, 0, 1'b1);
        run_seq(1, 0, 0, 1'b0);
        run_seq(33, -1, 0, 1'b1);

        // Abort while loading the third word
        do_start(1'b0, 4'd1);
        step();
        feed_word(32'hA5A5_0001, 1'b0, 0);
        step();
        feed_word(32'hA5A5_0002, 1'b0, 0);
        step();
        i_abort = 1'b1; i_data_valid = 1'b1; i_data = 32'h0BAD_0BAD;
        step();
        i_abort = 1'b0; i_data_valid = 1'b0;
        chk("abort_idle", 64'(o_busy), 64'd0);
        chk("abort_cnt", 64'(o_word_cnt), 64'd2);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", 64'({o_done, o_ig_load_ptr, o_ig_wdata_upd}), 64'd0);
            step();
        end
        do_start(1'b0, 4'd0);
        chk("restart_cnt", 64'(o_word_cnt), 64'd0);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("abort_clr", 64'(o_busy), 64'd0);

        run_seq(6, 5, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(1, 12));
            run_seq(n, n - 1, int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset while replay is running
        do_start(1'b1, 4'hF);
        step();
        feed_word(32'hDEAD_BEEF, 1'b1, 0);
        step();
        step();
        chk("pre_reset_run", 64'(o_ig_wdata_en), 64'd1);
        rst = 1'b1;
        step();
        chk("reset_mid_run", all_outputs(), 64'd0);
        rst = 1'b0;
        step();
        chk("post_reset_idle", all_outputs(), 64'd0);
        run_seq(3, 2, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
